// File: rtl/ahb_sram_ctrl_p_if.sv
// AHB-Lite slave-side bus bundle for ahb_sram_ctrl_p.
// The master modport is the interconnect/bench side; the slave modport is the controller side.
interface ahb_sram_ctrl_p_if #(
    parameter int DATA_W = 32
);
    logic              hsel;
    logic              hready;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [31:0]       haddr;
    logic [DATA_W-1:0] hwdata;
    logic [DATA_W-1:0] hrdata;
    logic              hready_resp;
    logic [1:0]        hresp;

    modport master (
        output hsel, hready, hwrite, htrans, hsize, hburst, haddr, hwdata,
        input  hrdata, hready_resp, hresp
    );

    modport slave (
        input  hsel, hready, hwrite, htrans, hsize, hburst, haddr, hwdata,
        output hrdata, hready_resp, hresp
    );
endinterface

// File: rtl/ahb_sram_ctrl_p.sv
// AHB-Lite slave bridging the bus to a multi-bank synchronous SRAM array.
// Writes complete with zero wait states, reads insert RD_LAT wait states, illegal transfers get a two-cycle ERROR.
module ahb_sram_ctrl_p #(
    parameter int DATA_W    = 32,
    parameter int NUM_BANKS = 2,
    parameter int BANK_AW   = 13,
    parameter int RD_LAT    = 1
) (
    input  logic                          hclk,
    input  logic                          hreset,
    ahb_sram_ctrl_p_if.slave              bus,
    output logic [NUM_BANKS-1:0]          sram_cs_n,
    output logic                          sram_we_n,
    output logic [DATA_W/8-1:0]           sram_be_n,
    output logic [BANK_AW-1:0]            sram_addr,
    output logic [DATA_W-1:0]             sram_wdata,
    input  logic [NUM_BANKS*DATA_W-1:0]   sram_rdata
);
    localparam int NB  = DATA_W / 8;
    localparam int LB  = $clog2(NB);
    localparam int BB  = $clog2(NUM_BANKS);
    localparam int BW  = (BB > 0) ? BB : 1;
    localparam int TOP = LB + BANK_AW + BB;
    localparam int CW  = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {IDLE, WR, RD, ERR1, ERR2} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
    logic [BW-1:0]     bank_q, bank_d;
    logic [BANK_AW-1:0] word_q, word_d;
    logic [NB-1:0]     mask_q, mask_d;

    logic              addr_ph;
    logic              req_err;
    logic [BW-1:0]     req_bank;
    logic [BANK_AW-1:0] req_word;
    logic [NB-1:0]     req_mask;
    logic [31:0]       hi_bits;
    logic [31:0]       align_mask;
    logic [31:0]       lane_bits;
    logic [DATA_W-1:0] lane_data_mask;
    logic              unused_hburst;

    assign unused_hburst = ^bus.hburst;

    // Address-phase decode; every beat is decoded from haddr alone, burst type is ignored.
    always_comb begin
        addr_ph    = bus.hsel & bus.hready & bus.htrans[1];
        req_word   = bus.haddr[LB +: BANK_AW];
        req_bank   = BW'((bus.haddr >> (LB + BANK_AW)) & 32'(NUM_BANKS - 1));
        hi_bits    = bus.haddr >> TOP;
        align_mask = (32'd1 << bus.hsize) - 32'd1;
        req_err    = (hi_bits != 32'd0) || (32'(bus.hsize) > 32'(LB))
                     || ((bus.haddr & align_mask) != 32'd0);
        lane_bits  = ((32'd1 << (32'd1 << bus.hsize)) - 32'd1) << bus.haddr[LB-1:0];
        req_mask   = lane_bits[NB-1:0];
    end

    always_comb begin
        lane_data_mask = '0;
        for (int i = 0; i < NB; i++) begin
            lane_data_mask[i*8 +: 8] = {8{mask_q[i]}};
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q  <= IDLE;
            rd_cnt_q <= '0;
            bank_q   <= '0;
            word_q   <= '0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            bank_q   <= bank_d;
            word_q   <= word_d;
            mask_q   <= mask_d;
        end
    end

    // Data-phase outputs; a new phase is only taken when the current one signals completion.
    always_comb begin
        state_d         = state_q;
        rd_cnt_d        = rd_cnt_q;
        bank_d          = bank_q;
        word_d          = word_q;
        mask_d          = mask_q;
        bus.hready_resp = 1'b1;
        bus.hresp       = 2'b00;
        bus.hrdata      = '0;
        sram_cs_n       = '1;
        sram_we_n       = 1'b1;
        sram_be_n       = '1;

        case (state_q)
            WR: begin
                sram_cs_n = ~(NUM_BANKS'(1) << bank_q);
                sram_we_n = 1'b0;
                sram_be_n = ~mask_q;
            end
            RD: begin
                if (rd_cnt_q == '0) begin
                    sram_cs_n = ~(NUM_BANKS'(1) << bank_q);
                    sram_be_n = ~mask_q;
                end
                if (rd_cnt_q != CW'(RD_LAT)) begin
                    bus.hready_resp = 1'b0;
                    rd_cnt_d        = rd_cnt_q + 1'b1;
                end else begin
                    bus.hrdata = sram_rdata[int'(bank_q)*DATA_W +: DATA_W] & lane_data_mask;
                end
            end
            ERR1: begin
                bus.hresp       = 2'b01;
                bus.hready_resp = 1'b0;
                state_d         = ERR2;
            end
            ERR2: begin
                bus.hresp = 2'b01;
            end
            default: ;
        endcase

        if (bus.hready_resp) begin
            rd_cnt_d = '0;
            if (addr_ph) begin
                bank_d = req_bank;
                word_d = req_word;
                mask_d = req_mask;
                if (req_err)         state_d = ERR1;
                else if (bus.hwrite) state_d = WR;
                else                 state_d = RD;
            end else begin
                state_d = IDLE;
            end
        end
    end

    assign sram_addr  = word_q;
    assign sram_wdata = bus.hwdata;
endmodule

// File: tb/tb_ahb_sram_ctrl_p.sv
// Scoreboard bench for ahb_sram_ctrl_p with a behavioural two-bank SRAM (RD_LAT-deep read pipe).
// Stimulus pushes the hand-computed response of each accepted address phase; a monitor pops on completion.
module tb_ahb_sram_ctrl_p;
    localparam int DATA_W    = 32;
    localparam int NUM_BANKS = 2;
    localparam int BANK_AW   = 13;
    localparam int RD_LAT    = 2;

    typedef struct packed {
        logic [7:0]  id;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [3:0]  waits;
        logic [1:0]  cs_n;
        logic        we_n;
        logic [3:0]  be_n;
        logic [12:0] addr;
    } exp_t;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic [1:0]  sram_cs_n;
    logic        sram_we_n;
    logic [3:0]  sram_be_n;
    logic [12:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [63:0] sram_rdata;

    logic [31:0] mem  [2][8192];
    logic [31:0] pipe [2][RD_LAT];

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    ahb_sram_ctrl_p_if #(.DATA_W(DATA_W)) bus ();

    assign bus.hready = bus.hready_resp;

    ahb_sram_ctrl_p #(
        .DATA_W(DATA_W), .NUM_BANKS(NUM_BANKS), .BANK_AW(BANK_AW), .RD_LAT(RD_LAT)
    ) dut (
        .hclk(hclk), .hreset(hreset), .bus(bus),
        .sram_cs_n(sram_cs_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 hclk = ~hclk;

    always @(posedge hclk) begin
        for (int b = 0; b < 2; b++) begin
            if (!sram_cs_n[b] && !sram_we_n) begin
                for (int l = 0; l < 4; l++) begin
                    if (!sram_be_n[l]) mem[b][sram_addr][l*8 +: 8] <= sram_wdata[l*8 +: 8];
                end
            end
            pipe[b][0] <= (!sram_cs_n[b] && sram_we_n) ? mem[b][sram_addr] : 32'h0;
            for (int s = 1; s < RD_LAT; s++) pipe[b][s] <= pipe[b][s-1];
        end
    end

    assign sram_rdata = {pipe[1][RD_LAT-1], pipe[0][RD_LAT-1]};

    function automatic exp_t mk(input int id, input logic [1:0] resp, input logic [31:0] rdata,
                                input int waits, input logic [1:0] cs_n, input logic we_n,
                                input logic [3:0] be_n, input logic [12:0] addr);
        exp_t e;
        e.id = 8'(id); e.resp = resp; e.rdata = rdata; e.waits = 4'(waits);
        e.cs_n = cs_n; e.we_n = we_n; e.be_n = be_n; e.addr = addr;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [1:0] trans, input logic [2:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input exp_t e, output int cyc);
        logic accepted;
        bus.hsel = 1'b1; bus.hwrite = wr; bus.htrans = trans; bus.hsize = size; bus.haddr = addr;
        accepted = 1'b0;
        cyc = 0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge hclk);
            if (bus.hready_resp) accepted = 1'b1;
            cyc++;
            @(posedge hclk);
        end
        #1;
        if (!accepted) checkOutput($sformatf("t%0d accept timeout", e.id), 32'd0, 32'd1);
        else begin
            exp_q.push_back(e);
            bus.hwdata = wdata;
        end
    endtask

    task automatic idleBus(input int n);
        bus.hsel = 1'b0; bus.htrans = 2'b00;
        repeat (n) @(posedge hclk);
        #1;
    endtask

    // Monitor: accumulates one data phase and checks it against the scoreboard when it completes.
    initial begin
        exp_t e;
        int   waits = 0, cs_cnt = 0;
        logic first = 1'b1, zero_ok = 1'b1;
        logic [1:0]  first_resp = 2'b00, obs_cs = 2'b11;
        logic        obs_we = 1'b1;
        logic [3:0]  obs_be = 4'hF;
        logic [12:0] obs_addr = '0;
        forever begin
            @(negedge hclk);
            if (hreset) begin
                waits = 0; cs_cnt = 0; first = 1'b1; zero_ok = 1'b1;
            end else begin
                if (first) begin
                    first_resp = bus.hresp; obs_cs = sram_cs_n; obs_we = sram_we_n;
                    obs_be = sram_be_n; obs_addr = '0; first = 1'b0;
                end
                if (sram_cs_n != 2'b11) begin
                    cs_cnt++; obs_cs = sram_cs_n; obs_we = sram_we_n;
                    obs_be = sram_be_n; obs_addr = sram_addr;
                end
                if (!bus.hready_resp) begin
                    waits++;
                    if (bus.hrdata != 32'h0) zero_ok = 1'b0;
                end else begin
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        checkOutput($sformatf("t%0d hresp", e.id), 32'(bus.hresp), 32'(e.resp));
                        checkOutput($sformatf("t%0d first hresp", e.id), 32'(first_resp), 32'(e.resp));
                        checkOutput($sformatf("t%0d hrdata", e.id), bus.hrdata, e.rdata);
                        checkOutput($sformatf("t%0d waits", e.id), 32'(waits), 32'(e.waits));
                        checkOutput($sformatf("t%0d cs_n", e.id), 32'(obs_cs), 32'(e.cs_n));
                        checkOutput($sformatf("t%0d cs cycles", e.id), 32'(cs_cnt),
                                    (e.cs_n == 2'b11) ? 32'd0 : 32'd1);
                        checkOutput($sformatf("t%0d we_n", e.id), 32'(obs_we), 32'(e.we_n));
                        checkOutput($sformatf("t%0d be_n", e.id), 32'(obs_be), 32'(e.be_n));
                        if (e.cs_n != 2'b11)
                            checkOutput($sformatf("t%0d sram_addr", e.id), 32'(obs_addr), 32'(e.addr));
                        checkOutput($sformatf("t%0d hrdata zero in waits", e.id), 32'(zero_ok), 32'd1);
                    end
                    waits = 0; cs_cnt = 0; first = 1'b1; zero_ok = 1'b1;
                end
            end
        end
    end

    initial begin
        int cyc;
        bus.hsel = 1'b0; bus.hwrite = 1'b0; bus.htrans = 2'b00; bus.hsize = 3'd2;
        bus.hburst = 3'd0; bus.haddr = 32'h0; bus.hwdata = 32'h0;

        #2;
        checkOutput("reset hready_resp", 32'(bus.hready_resp), 32'd1);
        checkOutput("reset hresp", 32'(bus.hresp), 32'd0);
        checkOutput("reset hrdata", bus.hrdata, 32'd0);
        checkOutput("reset cs_n", 32'(sram_cs_n), 32'h3);
        checkOutput("reset we_n", 32'(sram_we_n), 32'd1);
        checkOutput("reset be_n", 32'(sram_be_n), 32'hF);
        repeat (2) @(negedge hclk);
        hreset = 1'b0;
        @(posedge hclk); #1;

        $display("[TB] writes, pipelined reads, held NONSEQ");
        applyStimulus(1'b1, 2'b10, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, mk(1, 2'b00, 32'h0, 0, 2'b10, 1'b0, 4'b0000, 13'h4), cyc);
        applyStimulus(1'b1, 2'b10, 3'd0, 32'h0000_8003, 32'hAB00_0000, mk(2, 2'b00, 32'h0, 0, 2'b01, 1'b0, 4'b0111, 13'h0), cyc);
        applyStimulus(1'b0, 2'b10, 3'd0, 32'h0000_8003, 32'h0, mk(3, 2'b00, 32'hAB00_0000, 2, 2'b01, 1'b1, 4'b0111, 13'h0), cyc);
        applyStimulus(1'b1, 2'b10, 3'd2, 32'h0000_0020, 32'h1234_5678, mk(4, 2'b00, 32'h0, 0, 2'b10, 1'b0, 4'b0000, 13'h8), cyc);
        applyStimulus(1'b0, 2'b10, 3'd2, 32'h0000_0020, 32'h0, mk(5, 2'b00, 32'h1234_5678, 2, 2'b10, 1'b1, 4'b0000, 13'h8), cyc);
        applyStimulus(1'b1, 2'b10, 3'd2, 32'h0000_0024, 32'h55AA_55AA, mk(6, 2'b00, 32'h0, 0, 2'b10, 1'b0, 4'b0000, 13'h9), cyc);
        checkOutput("held NONSEQ accept cycles", 32'(cyc), 32'd3);
        applyStimulus(1'b0, 2'b11, 3'd1, 32'h0000_0026, 32'h0, mk(7, 2'b00, 32'h55AA_0000, 2, 2'b10, 1'b1, 4'b0011, 13'h9), cyc);
        applyStimulus(1'b0, 2'b10, 3'd1, 32'h0000_0010, 32'h0, mk(8, 2'b00, 32'h0000_BEEF, 2, 2'b10, 1'b1, 4'b1100, 13'h4), cyc);

        $display("[TB] IDLE/BUSY and error transfers");
        applyStimulus(1'b0, 2'b00, 3'd2, 32'h0000_0010, 32'h0, mk(9, 2'b00, 32'h0, 0, 2'b11, 1'b1, 4'hF, 13'h0), cyc);
        applyStimulus(1'b1, 2'b01, 3'd2, 32'h0000_0010, 32'h0, mk(10, 2'b00, 32'h0, 0, 2'b11, 1'b1, 4'hF, 13'h0), cyc);
        applyStimulus(1'b1, 2'b10, 3'd2, 32'h0001_0000, 32'hFFFF_FFFF, mk(11, 2'b01, 32'h0, 1, 2'b11, 1'b1, 4'hF, 13'h0), cyc);
        applyStimulus(1'b0, 2'b10, 3'd1, 32'h0000_0001, 32'h0, mk(12, 2'b01, 32'h0, 1, 2'b11, 1'b1, 4'hF, 13'h0), cyc);
        applyStimulus(1'b0, 2'b10, 3'd3, 32'h0000_0000, 32'h0, mk(13, 2'b01, 32'h0, 1, 2'b11, 1'b1, 4'hF, 13'h0), cyc);
        applyStimulus(1'b0, 2'b10, 3'd2, 32'h0000_0020, 32'h0, mk(14, 2'b00, 32'h1234_5678, 2, 2'b10, 1'b1, 4'b0000, 13'h8), cyc);
        idleBus(4);

        $display("[TB] reset during read wait state");
        applyStimulus(1'b0, 2'b10, 3'd2, 32'h0000_0020, 32'h0, mk(15, 2'b00, 32'h1234_5678, 2, 2'b10, 1'b1, 4'b0000, 13'h8), cyc);
        idleBus(1);
        checkOutput("rd_cnt=1 hready_resp", 32'(bus.hready_resp), 32'd0);
        #1 hreset = 1'b1;
        #1;
        checkOutput("mid-read reset hready_resp", 32'(bus.hready_resp), 32'd1);
        checkOutput("mid-read reset hresp", 32'(bus.hresp), 32'd0);
        checkOutput("mid-read reset cs_n", 32'(sram_cs_n), 32'h3);
        checkOutput("mid-read reset hrdata", bus.hrdata, 32'd0);
        exp_q.delete();
        @(posedge hclk); #2;
        hreset = 1'b0;
        @(posedge hclk); #1;
        applyStimulus(1'b0, 2'b10, 3'd0, 32'h0000_8003, 32'h0, mk(16, 2'b00, 32'hAB00_0000, 2, 2'b01, 1'b1, 4'b0111, 13'h0), cyc);
        applyStimulus(1'b0, 2'b10, 3'd2, 32'h0000_0010, 32'h0, mk(17, 2'b00, 32'hDEAD_BEEF, 2, 2'b10, 1'b1, 4'b0000, 13'h4), cyc);
        idleBus(6);
        checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ahb_sram_ctrl_p.md
# ahb_sram_ctrl_p

Parametrised AHB-Lite slave that bridges the system bus to a multi-bank synchronous SRAM array. It is the next generation of the single-cycle AHB-to-SRAM interface. Data width, bank count, bank depth and SRAM read latency are configurable. Reads insert wait states, and illegal transfers get a two-cycle ERROR response. The block sits between the AHB interconnect slave port and the SRAM bank macros.

## Interface
Parameters:
- DATA_W, 32, bus/SRAM word width; 32 or 64; LB = log2(DATA_W/8)
- NUM_BANKS, 2, SRAM banks, power of 2, 1..8; BB = log2(NUM_BANKS)
- BANK_AW, 13, word-address bits per bank
- RD_LAT, 1, SRAM read latency in cycles (1..4) = read wait states

Ports:
- hclk  in  1  bus clock
- hreset  in  1  asynchronous, active-high reset
- hsel  in  1  slave select
- hready  in  1  bus ready (previous transfer complete)
- hwrite  in  1  1 = write
- htrans  in  2  IDLE 00, BUSY 01, NONSEQ 10, SEQ 11
- hsize  in  3  transfer size, 2^hsize bytes
- hburst  in  3  burst type (ignored; every beat decoded from haddr)
- haddr  in  32  byte address
- hwdata  in  DATA_W  write data
- hrdata  out  DATA_W  read data
- hready_resp  out  1  transfer-done
- hresp  out  2  00 OKAY, 01 ERROR
- sram_cs_n  out  NUM_BANKS  per-bank chip select, active low
- sram_we_n  out  1  0 = write
- sram_be_n  out  DATA_W/8  byte-lane enables, active low
- sram_addr  out  BANK_AW  word address within bank
- sram_wdata  out  DATA_W  write data
- sram_rdata  in  NUM_BANKS*DATA_W  bank b occupies bits [b*DATA_W +: DATA_W]

## Operation
- Address phase is captured when hsel & hready & htrans[1]. Otherwise (IDLE, BUSY, unselected) the block gives a zero-wait OKAY with no SRAM access.
- Address decode:
  - lane offset = haddr[LB-1:0]
  - word = haddr[LB+BANK_AW-1:LB]
  - bank = next BB bits
- ERROR conditions:
  - any haddr bit above LB+BANK_AW+BB is set
  - hsize > LB
  - the transfer is misaligned (haddr mod 2^hsize != 0)
- Lane mask: 2^hsize consecutive lanes starting at the lane offset. Little-endian, lanes stay in place (no shifting).
- FSM states: IDLE, WR, RD, ERR1, ERR2. From any cycle where hready_resp = 1, the next state comes from the captured phase: write → WR, read → RD, error → ERR1, none → IDLE.
- WR (1 cycle):
  - sram_cs_n[bank] = 0, sram_we_n = 0, sram_be_n = ~mask
  - sram_addr = word, sram_wdata = hwdata
  - hready_resp = 1, OKAY
- RD:
  - rd_cnt counts 0..RD_LAT.
  - cs_n[bank] = 0, we_n = 1, be_n = ~mask only at rd_cnt = 0. sram_addr is held for the whole state.
  - hready_resp = 0 while rd_cnt < RD_LAT.
  - At rd_cnt = RD_LAT: hready_resp = 1, hrdata = bank slice of sram_rdata AND lane mask (inactive lanes 0).
- ERR1: hresp = 01, hready_resp = 0. ERR2: hresp = 01, hready_resp = 1. No SRAM access in either.
- hrdata = 0 in every cycle other than a read completion.
- Idle values: sram_cs_n all 1, sram_we_n = 1, sram_be_n all 1. sram_wdata = hwdata at all times.

## Timing
- Writes: zero wait states; SRAM write occurs in the single data-phase cycle.
- Reads: RD_LAT wait states. Data-phase length is RD_LAT+1 cycles; SRAM data is sampled combinationally in the last one.
- A write data phase directly followed by a read to the same address returns the new data. The SRAM write completes before the read's chip select.
- While hready_resp = 0, no new address phase is captured.
- Reset (async, at any time, including mid-RD or mid-ERR1) takes effect immediately:
  - state IDLE, rd_cnt 0
  - hready_resp = 1, hresp = 00, hrdata = 0
  - sram_cs_n, sram_we_n, sram_be_n all 1, captured phase cleared
  - first transfer may start on the first edge after deassertion.

## Test plan
(DATA_W=32, NUM_BANKS=2, BANK_AW=13, RD_LAT=2)
- Word write haddr=0x0000_0010, hwdata=0xDEADBEEF → data cycle: cs_n=2'b10, we_n=0, be_n=4'b0000, sram_addr=0x0004, hready_resp=1, hresp=00.
- Byte write haddr=0x0000_8003, hwdata=0xAB00_0000, then byte read of the same address → write: cs_n=2'b01, be_n=4'b0111, addr=0x0000. Read: 2 cycles hready_resp=0, then hrdata=0xAB00_0000.
- Pipelined write 0x20 (0x1234_5678) → read 0x20 → NONSEQ to 0x24 held → read returns 0x1234_5678 after 2 wait states. The 0x24 phase is captured only on the completion cycle.
- haddr=0x0001_0000 word; haddr=0x0000_0001 halfword; hsize=3 → each gives ERR1 (hresp=01, hready_resp=0) then ERR2 (hresp=01, hready_resp=1); cs_n stays 2'b11.
- IDLE and BUSY htrans with hsel=1 → hready_resp=1, hresp=00, no cs_n activity.
- hreset pulsed during RD at rd_cnt=1 → same cycle: hready_resp=1, cs_n=2'b11, hrdata=0. Next read after release behaves normally.
